regfile_scoreboard: RTL and testbench



---
 rtl/regfile_scoreboard.sv | 138 +++++++++++++
 tb/tb_regfile_scoreboard.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: DEPTH x WIDTH register file with a per-register busy
// scoreboard. Decode reads two registers (with busy flags) and claims a
// destination; writeback writes a register and releases its busy bit.
//
// Ports:
//   clock, reset           rising-edge clock, async active-high reset
//   clear                  synchronous clear of data, busy bits and busy_count
//   rd_sel1/2              read addresses
//   rd_data1/2, rd_busy1/2 combinational read data and busy flags
//   we, wr_sel, wr_data    write port (also releases the busy bit)
//   claim, claim_sel       mark a register busy
//   busy_count             registered popcount of the busy vector
//
// Optional build macro: REGFILE_BYPASS_EN enables write-through bypass on the
// read ports. When it is undefined, reads show stored state only.

module regfile_scoreboard #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic [$clog2(DEPTH)-1:0]   rd_sel1,
    input  logic [$clog2(DEPTH)-1:0]   rd_sel2,
    output logic [WIDTH-1:0]           rd_data1,
    output logic [WIDTH-1:0]           rd_data2,
    output logic                       rd_busy1,
    output logic                       rd_busy2,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   wr_sel,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       claim,
    input  logic [$clog2(DEPTH)-1:0]   claim_sel,
    output logic [$clog2(DEPTH):0]     busy_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [CW-1:0]    r_busy_count;

    logic             w_we_ok;
    logic             w_claim_ok;
    logic [DEPTH-1:0] w_busy_nxt;
    logic [CW-1:0]    w_count_nxt;

    // Register 0 is untouchable when hardwired to zero.
    assign w_we_ok    = we    && !((ZERO_REG != 0) && (wr_sel    == AW'(0)));
    assign w_claim_ok = claim && !((ZERO_REG != 0) && (claim_sel == AW'(0)));

    // Next busy vector: release on write, then set on claim so a same-register
    // claim wins over the release.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_we_ok) begin
            w_busy_nxt[wr_sel] = 1'b0;
        end
        if (w_claim_ok) begin
            w_busy_nxt[claim_sel] = 1'b1;
        end
        if (clear) begin
            w_busy_nxt = '0;
        end
    end

    // Popcount of the next busy vector keeps busy_count exact by construction.
    always_comb begin
        w_count_nxt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_count_nxt = w_count_nxt + CW'(w_busy_nxt[i]);
        end
    end

    // Data storage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we_ok) begin
            r_regs[wr_sel] <= wr_data;
        end
    end

    // Scoreboard state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            r_busy       <= w_busy_nxt;
            r_busy_count <= w_count_nxt;
        end
    end

    assign busy_count = r_busy_count;

    // Read port 1.
    always_comb begin
        rd_data1 = r_regs[rd_sel1];
        rd_busy1 = r_busy[rd_sel1];
`ifdef REGFILE_BYPASS_EN
        if (w_we_ok && (wr_sel == rd_sel1)) begin
            rd_data1 = wr_data;
            rd_busy1 = w_claim_ok && (claim_sel == rd_sel1);
        end
`endif
        if (((ZERO_REG != 0) && (rd_sel1 == AW'(0))) || reset) begin
            rd_data1 = '0;
            rd_busy1 = 1'b0;
        end
    end

    // Read port 2.
    always_comb begin
        rd_data2 = r_regs[rd_sel2];
        rd_busy2 = r_busy[rd_sel2];
`ifdef REGFILE_BYPASS_EN
        if (w_we_ok && (wr_sel == rd_sel2)) begin
            rd_data2 = wr_data;
            rd_busy2 = w_claim_ok && (claim_sel == rd_sel2);
        end
`endif
        if (((ZERO_REG != 0) && (rd_sel2 == AW'(0))) || reset) begin
            rd_data2 = '0;
            rd_busy2 = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

    logic        clock;
    logic        reset;
    logic        clear;
    logic [4:0]  rd_sel1;
    logic [4:0]  rd_sel2;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic        rd_busy1;
    logic        rd_busy2;
    logic        we;
    logic [4:0]  wr_sel;
    logic [31:0] wr_data;
    logic        claim;
    logic [4:0]  claim_sel;
    logic [5:0]  busy_count;

    int checks   = 0;
    int failures = 0;

    regfile_scoreboard #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .rd_sel1    (rd_sel1),
        .rd_sel2    (rd_sel2),
        .rd_data1   (rd_data1),
        .rd_data2   (rd_data2),
        .rd_busy1   (rd_busy1),
        .rd_busy2   (rd_busy2),
        .we         (we),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .claim      (claim),
        .claim_sel  (claim_sel),
        .busy_count (busy_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, land 1 time unit after it, drop single-cycle strobes.
    task automatic step();
        @(posedge clock);
        #1;
        we    = 1'b0;
        claim = 1'b0;
        clear = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] sel, input logic [31:0] data);
        we = 1'b1; wr_sel = sel; wr_data = data;
    endtask

    task automatic do_claim(input logic [4:0] sel);
        claim = 1'b1; claim_sel = sel;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; we = 1'b0; claim = 1'b0;
        wr_sel = '0; wr_data = '0; claim_sel = '0;
        rd_sel1 = 5'd5; rd_sel2 = 5'd7;
        #12;
        check("rst_data", 64'(rd_data1), 64'h0);
        check("rst_busy", 64'(rd_busy2), 64'h0);
        check("rst_cnt",  64'(busy_count), 64'h0);
        reset = 1'b0;
        step();

        // Async reset mid-cycle
        do_write(5'd5, 32'hDEADBEEF); do_claim(5'd7);
        step();
        check("pre_rst_data", 64'(rd_data1), 64'hDEADBEEF);
        check("pre_rst_busy", 64'(rd_busy2), 64'h1);
        check("pre_rst_cnt",  64'(busy_count), 64'h1);
        #2 reset = 1'b1;
        #1;
        check("arst_data", 64'(rd_data1), 64'h0);
        check("arst_busy", 64'(rd_busy2), 64'h0);
        check("arst_cnt",  64'(busy_count), 64'h0);
        #3 reset = 1'b0;
        step();
        check("arst_hold_data", 64'(rd_data1), 64'h0);

        // Synchronous clear, with priority over same-cycle write/claim
        do_write(5'd5, 32'hDEADBEEF); do_claim(5'd7);
        step();
        check("pre_clr_cnt", 64'(busy_count), 64'h1);
        clear = 1'b1; do_write(5'd6, 32'h55); do_claim(5'd8);
        #1;
        check("clr_before_edge", 64'(rd_data1), 64'hDEADBEEF);
        step();
        check("clr_data", 64'(rd_data1), 64'h0);
        check("clr_busy", 64'(rd_busy2), 64'h0);
        check("clr_cnt",  64'(busy_count), 64'h0);
        rd_sel1 = 5'd6; rd_sel2 = 5'd8;
        #1;
        check("clr_prio_data", 64'(rd_data1), 64'h0);
        check("clr_prio_busy", 64'(rd_busy2), 64'h0);

        // Claim then release
        rd_sel1 = 5'd3; rd_sel2 = 5'd3;
        do_claim(5'd3);
        step();
        check("claim_busy", 64'(rd_busy1), 64'h1);
        check("claim_cnt",  64'(busy_count), 64'h1);
        do_write(5'd3, 32'h12345678);
        step();
        check("rel_busy", 64'(rd_busy2), 64'h0);
        check("rel_cnt",  64'(busy_count), 64'h0);
        check("rel_data", 64'(rd_data1), 64'h12345678);

        // Re-claim of busy register is a no-op; same-cycle claim+write
        rd_sel1 = 5'd9; rd_sel2 = 5'd9;
        do_claim(5'd9);
        step();
        check("c9_cnt", 64'(busy_count), 64'h1);
        do_claim(5'd9);
        step();
        check("reclaim_cnt", 64'(busy_count), 64'h1);
        do_claim(5'd9); do_write(5'd9, 32'hA5A5A5A5);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("cw_comb_data", 64'(rd_data1), 64'hA5A5A5A5);
`else
        check("cw_comb_data", 64'(rd_data1), 64'h0);
`endif
        check("cw_comb_busy", 64'(rd_busy1), 64'h1);
        step();
        check("cw_data", 64'(rd_data2), 64'hA5A5A5A5);
        check("cw_busy", 64'(rd_busy1), 64'h1);
        check("cw_cnt",  64'(busy_count), 64'h1);
        do_write(5'd9, 32'h0);
        step();
        check("r9_rel_cnt", 64'(busy_count), 64'h0);

        // Claim and write to different registers
        rd_sel1 = 5'd10; rd_sel2 = 5'd11;
        do_claim(5'd10);
        step();
        do_write(5'd10, 32'hCAFE); do_claim(5'd11);
        step();
        check("diff_busy10", 64'(rd_busy1), 64'h0);
        check("diff_busy11", 64'(rd_busy2), 64'h1);
        check("diff_data10", 64'(rd_data1), 64'hCAFE);
        check("diff_cnt",    64'(busy_count), 64'h1);
        do_write(5'd11, 32'h1);
        step();
        check("r11_rel_cnt", 64'(busy_count), 64'h0);

        // Write to a non-busy register leaves busy clear
        do_write(5'd11, 32'h2);
        step();
        check("nb_busy", 64'(rd_busy2), 64'h0);
        check("nb_data", 64'(rd_data2), 64'h2);

        // Zero register
        rd_sel1 = 5'd0; rd_sel2 = 5'd0;
        do_write(5'd0, 32'hFFFFFFFF); do_claim(5'd0);
        #1;
        check("r0_comb_data", 64'(rd_data1), 64'h0);
        check("r0_comb_busy", 64'(rd_busy2), 64'h0);
        step();
        check("r0_data", 64'(rd_data1), 64'h0);
        check("r0_busy", 64'(rd_busy2), 64'h0);
        check("r0_cnt",  64'(busy_count), 64'h0);

        // Bypass / write latency
        rd_sel1 = 5'd4; rd_sel2 = 5'd4;
        do_write(5'd4, 32'h11);
        step();
        check("r4_init", 64'(rd_data1), 64'h11);
        do_write(5'd4, 32'h22);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_p1", 64'(rd_data1), 64'h22);
        check("byp_p2", 64'(rd_data2), 64'h22);
`else
        check("byp_p1", 64'(rd_data1), 64'h11);
        check("byp_p2", 64'(rd_data2), 64'h11);
`endif
        check("byp_busy", 64'(rd_busy1), 64'h0);
        step();
        check("post_p1", 64'(rd_data1), 64'h22);
        check("post_p2", 64'(rd_data2), 64'h22);

        // Count saturation: claim r1..r31, re-claim r1, then release all
        for (int i = 1; i < 32; i++) begin
            do_claim(5'(i));
            step();
            check("sat_up", 64'(busy_count), 64'(i));
        end
        do_claim(5'd1);
        step();
        check("sat_reclaim", 64'(busy_count), 64'd31);
        rd_sel1 = 5'd31; rd_sel2 = 5'd1;
        #1;
        check("sat_busy31", 64'(rd_busy1), 64'h1);
        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), 32'(i));
            step();
            check("sat_down", 64'(busy_count), 64'(31 - i));
        end
        check("sat_end_busy", 64'(rd_busy1), 64'h0);
        check("sat_end_data", 64'(rd_data1), 64'd31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
